// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester round-robin arbiter and access sequencer for the
// single-port DataMemory (combinational read, posedge write).
// m0 is the CPU load/store unit, m1 a secondary master (debug/DMA).
// Optional build macro DMEM_ARB_LOCK_LIMIT_EN bounds a locked burst to MAX_LOCK
// beats whenever the other requester is waiting.
module dmem_arbiter #(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 32,
   parameter int MAX_LOCK = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              m0_req,
   input  logic              m0_lock,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_lock,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   state_t            state_r;
   state_t            state_nxt_s;
   logic              rr_ptr_r;       // 1'b0 = m0 has priority on a tie
   logic              rr_ptr_nxt_s;
   logic              beat0_s;
   logic              beat1_s;
   logic              force0_s;       // lock limit forces m0 to release
   logic              force1_s;       // lock limit forces m1 to release
   logic              m0_rvalid_r;
   logic              m1_rvalid_r;
   logic [DATA_W-1:0] m0_rdata_r;
   logic [DATA_W-1:0] m1_rdata_r;

   // A beat is an owned cycle in which the owner still requests.
   assign beat0_s = (state_r == OWN0) & m0_req;
   assign beat1_s = (state_r == OWN1) & m1_req;

`ifdef DMEM_ARB_LOCK_LIMIT_EN
   logic [7:0] beat_cnt_r;
   logic       limit_hit_s;

   // The current beat is the MAX_LOCK-th consecutive one when the count of
   // already completed beats has reached MAX_LOCK-1.
   assign limit_hit_s = (beat_cnt_r >= 8'(MAX_LOCK - 1));
   assign force0_s    = limit_hit_s & m1_req;
   assign force1_s    = limit_hit_s & m0_req;

   // Consecutive-beat counter: cleared whenever the FSM heads to IDLE,
   // saturates at the limit while the other side stays quiet.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt_r <= 8'd0;
      end else if (state_nxt_s == IDLE) begin
         beat_cnt_r <= 8'd0;
      end else if ((beat0_s | beat1_s) & ~limit_hit_s) begin
         beat_cnt_r <= beat_cnt_r + 8'd1;
      end else begin
         beat_cnt_r <= beat_cnt_r;
      end
   end
`else
   assign force0_s = 1'b0;
   assign force1_s = 1'b0;
`endif

   // Next-state and round-robin pointer update.
   always_comb begin
      state_nxt_s  = state_r;
      rr_ptr_nxt_s = rr_ptr_r;
      case (state_r)
         IDLE: begin
            if (m0_req & m1_req) begin
               state_nxt_s = rr_ptr_r ? OWN1 : OWN0;
            end else if (m0_req) begin
               state_nxt_s = OWN0;
            end else if (m1_req) begin
               state_nxt_s = OWN1;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         OWN0: begin
            if (m0_req & m0_lock & ~force0_s) begin
               state_nxt_s = OWN0;
            end else begin
               state_nxt_s  = IDLE;
               rr_ptr_nxt_s = 1'b1;
            end
         end
         OWN1: begin
            if (m1_req & m1_lock & ~force1_s) begin
               state_nxt_s = OWN1;
            end else begin
               state_nxt_s  = IDLE;
               rr_ptr_nxt_s = 1'b0;
            end
         end
         default: begin
            state_nxt_s  = IDLE;
            rr_ptr_nxt_s = 1'b0;
         end
      endcase
   end

   // State and round-robin pointer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         rr_ptr_r <= 1'b0;
      end else begin
         state_r  <= state_nxt_s;
         rr_ptr_r <= rr_ptr_nxt_s;
      end
   end

   // Memory-side mux: only the owner drives the memory; outside ownership
   // everything is zero so an async reset kills a write within the cycle.
   always_comb begin
      mem_addr  = {ADDR_W{1'b0}};
      mem_wdata = {DATA_W{1'b0}};
      mem_we    = 1'b0;
      case (state_r)
         OWN0: begin
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
            mem_we    = m0_we & m0_req;
         end
         OWN1: begin
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
            mem_we    = m1_we & m1_req;
         end
         default: begin
            mem_addr  = {ADDR_W{1'b0}};
            mem_wdata = {DATA_W{1'b0}};
            mem_we    = 1'b0;
         end
      endcase
   end

   // Read return path: capture memory data on a read beat, pulse rvalid for
   // the following cycle, hold rdata until the next read beat of that port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m0_rvalid_r <= 1'b0;
         m1_rvalid_r <= 1'b0;
         m0_rdata_r  <= {DATA_W{1'b0}};
         m1_rdata_r  <= {DATA_W{1'b0}};
      end else begin
         m0_rvalid_r <= beat0_s & ~m0_we;
         m1_rvalid_r <= beat1_s & ~m1_we;
         if (beat0_s & ~m0_we) begin
            m0_rdata_r <= mem_rdata;
         end else begin
            m0_rdata_r <= m0_rdata_r;
         end
         if (beat1_s & ~m1_we) begin
            m1_rdata_r <= mem_rdata;
         end else begin
            m1_rdata_r <= m1_rdata_r;
         end
      end
   end

   assign m0_gnt    = (state_r == OWN0);
   assign m1_gnt    = (state_r == OWN1);
   assign m0_rvalid = m0_rvalid_r;
   assign m1_rvalid = m1_rvalid_r;
   assign m0_rdata  = m0_rdata_r;
   assign m1_rdata  = m1_rdata_r;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and access sequencer for the single-port DataMemory (one combinational read port, one posedge write port).
- Port m0 is the CPU load/store unit. Port m1 is a secondary master (debug/DMA).
- Grants one owner at a time using round-robin, with an optional multi-beat lock.
- Muxes the owner's address and write controls onto the memory and returns registered read data with a valid pulse.

Parameters:
- ADDR_W, 16, memory address width (matches DataMemory data_address)
- DATA_W, 32, data width
- MAX_LOCK, 16, max consecutive locked beats; used only with DMEM_ARB_LOCK_LIMIT_EN; legal range 1..255

Ports:
- clk  in  1  system clock, all state on posedge
- rst_n  in  1  asynchronous active-low reset
- m0_req  in  1  m0 access request; held until serviced
- m0_lock  in  1  m0 keeps ownership after the current beat
- m0_we  in  1  m0 write (1) / read (0)
- m0_addr  in  ADDR_W  m0 address
- m0_wdata  in  DATA_W  m0 write data
- m0_gnt  out  1  m0 owns the memory (registered)
- m0_rvalid  out  1  one-cycle pulse, m0_rdata valid
- m0_rdata  out  DATA_W  m0 read data (registered)
- m1_*  same set as m0_* for requester 1
- mem_addr  out  ADDR_W  to DataMemory data_address
- mem_we  out  1  to DataMemory write_en
- mem_wdata  out  DATA_W  to DataMemory write_data
- mem_rdata  in  DATA_W  from DataMemory read_data

Behaviour:
- Reset is one clock domain, asynchronous, active-low. On assertion, immediately:
  - state=IDLE, rr_ptr=m0
  - gnt, rvalid, rdata=0
  - mem_we=0 combinationally, so no write can occur at the next edge.
- FSM states: IDLE, OWN0, OWN1. gnt_x = (state==OWNx).
- IDLE transitions:
  - Only m0_req: go to OWN0.
  - Only m1_req: go to OWN1.
  - Both: go to OWN[rr_ptr].
  - Neither: stay in IDLE.
  - No memory access happens in IDLE.
- Memory outputs:
  - In OWNx: mem_addr=mx_addr, mem_wdata=mx_wdata, mem_we = mx_we & mx_req.
  - Otherwise mem_addr, mem_wdata, mem_we are all 0.
- Beat: a cycle in OWNx with mx_req=1. The access commits at the closing posedge.
  - Read beat: mx_rdata<=mem_rdata and mx_rvalid=1 for the following cycle only.
  - Write beat: no rvalid.
- OWNx exit after a beat:
  - mx_lock=0: go to IDLE, rr_ptr <= other requester.
  - mx_lock=1: stay in OWNx. Back-to-back beats run at one per cycle.
- OWNx with mx_req=0: no access, go to IDLE, rr_ptr <= other requester.
- Latency: req at cycle 0 (state IDLE), gnt at cycle 1, access commits at end of cycle 1, rvalid/rdata at cycle 2.
- Unlocked requesters alternate with a 1-cycle IDLE gap. Steady state: 1 access per 2 cycles.
- Requester rule: mx_addr/we/wdata must be stable while mx_req=1 and gnt=0. The arbiter never samples them outside OWNx.
- rdata holds its last value until the next read beat for that port.
- Reset mid-beat: the write is aborted, and the in-flight rvalid is cleared.

Optional Feature:
- Macro: DMEM_ARB_LOCK_LIMIT_EN.
- With the macro:
  - An 8-bit beat counter counts consecutive beats in OWNx; it is cleared on entry to IDLE.
  - When the count reaches MAX_LOCK and the other requester has req=1, go to IDLE and rr_ptr <= other, even if mx_lock=1.
  - If the other requester is idle, the lock continues and the counter saturates.
- Without the macro: no counter; lock is honoured indefinitely.

Test Plan:
- Reset, then m0 read addr 0x0005 → m0_gnt=1 at cycle 1, m0_rvalid=1 with m0_rdata=5 at cycle 2, m1 outputs stay 0.
- m0 write 0xDEADBEEF to 0x0010, then m0 read 0x0010 → mem_we=1 for exactly one cycle, readback 0xDEADBEEF.
- m0 and m1 both read continuously from reset (0x0001, 0x0002) → grants alternate m0,m1,m0,m1 with IDLE between each; rdata 1 and 2 respectively.
- m1 lock=1 for 4 beats (0x20..0x23) while m0_req=1 → m1 gets 4 consecutive cycles, then m0 is granted; m0 never sees gnt during the lock.
- Macro on, MAX_LOCK=3, m1 locked continuously, m0_req=1 → m1 gets exactly 3 beats, then m0 is granted.
- rst_n low during an m1 write beat to 0x0030 → mem_we drops immediately, ram[0x30] is unchanged (reads back 0x30), all outputs are 0.
